// File: rtl/dmem_responder.sv
// Behavioural data-memory responder: captures one word-aligned read or write,
// holds it for LATENCY cycles, commits or returns the word, then pulses ready.
`ifndef XLEN
`define XLEN 32
`endif

module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [`XLEN-1:0] i_DM_Wd,
  input  logic [`XLEN-1:0] i_DM_Addr,
  input  logic             i_DM_Wen,
  input  logic             i_DM_MemRead,
  input  logic [3:0]       i_DM_byte_en,
  output logic [`XLEN-1:0] o_DM_ReadData,
  output logic             o_DM_data_ready
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [`XLEN-1:0] mem [DEPTH];

  logic             req;
  logic             accept;
  logic             commit;
  logic [AW-1:0]    idx_p0;
  logic [`XLEN-1:0] wd_p0;
  logic [3:0]       be_p0;
  logic             wr_p0;
  logic [AW-1:0]    idx_sel;
  logic [`XLEN-1:0] wd_sel;
  logic [3:0]       be_sel;
  logic             wr_sel;
  logic             unused_addr;

  assign req         = i_DM_Wen | i_DM_MemRead;
  assign accept      = (state == IDLE) && req;
  assign commit      = i_rst && (state != RESP) && (state_nxt == RESP);
  assign unused_addr = ^{i_DM_Addr[`XLEN-1:AW+2], i_DM_Addr[1:0]};

  // With LATENCY=1 the commit happens on the accept edge, so the live inputs are used
  always_comb begin
    if (state == IDLE) begin
      idx_sel = i_DM_Addr[AW+1:2];
      wd_sel  = i_DM_Wd;
      be_sel  = i_DM_byte_en;
      wr_sel  = i_DM_Wen;
    end else begin
      idx_sel = idx_p0;
      wd_sel  = wd_p0;
      be_sel  = be_p0;
      wr_sel  = wr_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: begin
        if (!req)             state_nxt = IDLE;
        else if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_DM_data_ready = (state == RESP);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)              cnt <= 4'd0;
    else if (accept)         cnt <= CNT_INIT;
    else if (state == WAIT)  cnt <= cnt - 4'd1;
  end

  // ---- request capture stage (p0) ----
  always_ff @(posedge i_clk) begin
    if (accept) begin
      idx_p0 <= i_DM_Addr[AW+1:2];
      wd_p0  <= i_DM_Wd;
      be_p0  <= i_DM_byte_en;
      wr_p0  <= i_DM_Wen;
    end
  end

  // ---- commit stage ----
  always_ff @(posedge i_clk) begin
    if (commit && wr_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (be_sel[i]) mem[idx_sel][8*i +: 8] <= wd_sel[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)                 o_DM_ReadData <= '0;
    else if (commit && !wr_sel) o_DM_ReadData <= mem[idx_sel];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances (LATENCY 1/2/4/15) driven in parallel,
// checked every cycle against a transaction-level memory model plus literal checks.
module tb_dmem_responder;
  localparam int N = 4;
  localparam int LATS [N] = '{1, 2, 4, 15};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wd    [N];
  logic [31:0] addr  [N];
  logic        wen   [N];
  logic        mrd   [N];
  logic [3:0]  be    [N];
  logic [31:0] rdata [N];
  logic        rdy   [N];

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(.DEPTH(1024), .LATENCY(LATS[g])) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_DM_Wd(wd[g]), .i_DM_Addr(addr[g]),
      .i_DM_Wen(wen[g]), .i_DM_MemRead(mrd[g]), .i_DM_byte_en(be[g]),
      .o_DM_ReadData(rdata[g]), .o_DM_data_ready(rdy[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one pending transaction per instance, memory as a plain array
  logic [31:0] rmem  [N][1024];
  logic [3:0]  known [N][1024];
  bit          busy  [N];
  int          age   [N];
  bit          c_wr  [N];
  int          c_idx [N];
  logic [31:0] c_wd  [N];
  logic [3:0]  c_be  [N];
  bit          e_rdy [N];
  logic [31:0] e_rd  [N];
  bit          e_ok  [N];

  task automatic model_edge(input int k);
    bit req;
    bit commit;
    if (!rst) begin
      busy[k] = 0; e_rdy[k] = 0; e_rd[k] = '0; e_ok[k] = 1;
      return;
    end
    req    = wen[k] | mrd[k];
    commit = 0;
    if (e_rdy[k]) begin
      commit = 0;
    end else if (!busy[k]) begin
      if (req) begin
        c_wr[k] = wen[k]; c_idx[k] = int'(addr[k][11:2]);
        c_wd[k] = wd[k];  c_be[k]  = be[k];
        busy[k] = 1; age[k] = 0;
        if (LATS[k] == 1) commit = 1;
      end
    end else begin
      age[k]++;
      if (!req) busy[k] = 0;
      else if (age[k] == LATS[k] - 1) commit = 1;
    end
    e_rdy[k] = commit;
    if (commit) begin
      busy[k] = 0;
      if (c_wr[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (c_be[k][b]) begin
            rmem[k][c_idx[k]][8*b +: 8] = c_wd[k][8*b +: 8];
            known[k][c_idx[k]][b] = 1'b1;
          end
        end
      end else begin
        e_rd[k] = rmem[k][c_idx[k]];
        e_ok[k] = (known[k][c_idx[k]] == 4'hF);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 1024; i++) known[k][i] = 4'h0;
    forever begin
      @(posedge clk);
      for (int k = 0; k < N; k++) model_edge(k);
      #1;
      if (mon_en) begin
        for (int k = 0; k < N; k++) begin
          chk($sformatf("ready[%0d]", k), {31'b0, rdy[k]}, {31'b0, e_rdy[k]});
          if (e_ok[k]) chk($sformatf("rdata[%0d]", k), rdata[k], e_rd[k]);
        end
      end
    end
  end

  task automatic drive(input int k, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    wen[k] = w; mrd[k] = r; addr[k] = a; wd[k] = d; be[k] = b;
  endtask

  task automatic xact(input int k, input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      output logic [31:0] got, output int lat);
    @(negedge clk);
    drive(k, w, r, a, d, b);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (rdy[k]) lat = n;
    end
    got = rdata[k];
    if (lat == 0) chk($sformatf("timeout[%0d]", k), 32'd0, 32'd1);
    @(negedge clk);
    drive(k, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic run_inst(input int k);
    logic [31:0] got;
    logic [31:0] prev;
    int lat;
    int gap;
    int seen;
    string s;
    s = $sformatf("[%0d]", k);
    xact(k, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, got, lat);
    chk({"wr_latency", s}, lat, LATS[k]);
    xact(k, 0, 1, 32'h10, 32'h0, 4'h0, got, lat);
    chk({"rd_latency", s}, lat, LATS[k]);
    chk({"rd_deadbeef", s}, got, 32'hDEADBEEF);
    xact(k, 1, 0, 32'h20, 32'h11223344, 4'hF, got, lat);
    xact(k, 1, 0, 32'h20, 32'h00AA0000, 4'b0100, got, lat);
    xact(k, 0, 1, 32'h20, 32'h0, 4'h0, got, lat);
    chk({"lane2", s}, got, 32'h11AA3344);
    xact(k, 1, 0, 32'h20, 32'hBB000000, 4'b1000, got, lat);
    xact(k, 0, 1, 32'h20, 32'h0, 4'h0, got, lat);
    chk({"lane3", s}, got, 32'hBBAA3344);
    xact(k, 1, 0, 32'h20, 32'h12345678, 4'b0000, got, lat);
    chk({"be0_latency", s}, lat, LATS[k]);
    xact(k, 0, 1, 32'h20, 32'h0, 4'h0, got, lat);
    chk({"be0_unchanged", s}, got, 32'hBBAA3344);
    xact(k, 1, 0, 32'h1000, 32'h5A5A0001, 4'hF, got, lat);
    xact(k, 0, 1, 32'h0, 32'h0, 4'h0, got, lat);
    chk({"alias", s}, got, 32'h5A5A0001);
    // both requests high: a write, ReadData keeps the previous read
    xact(k, 0, 1, 32'h10, 32'h0, 4'h0, prev, lat);
    xact(k, 1, 1, 32'h20, 32'hFFFFFFFF, 4'hF, got, lat);
    chk({"prio_rdata_held", s}, got, 32'hDEADBEEF);
    xact(k, 0, 1, 32'h20, 32'h0, 4'h0, got, lat);
    chk({"prio_written", s}, got, 32'hFFFFFFFF);
    // back-to-back reads with the request held
    @(negedge clk);
    drive(k, 0, 1, 32'h10, 32'h0, 4'h0);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin @(posedge clk); #1; if (rdy[k]) lat = n; end
    gap = 0;
    for (int n = 1; n <= 40 && gap == 0; n++) begin @(posedge clk); #1; if (rdy[k]) gap = n; end
    chk({"b2b_first", s}, lat, LATS[k]);
    chk({"b2b_spacing", s}, gap, LATS[k] + 1);
    chk({"b2b_rdata", s}, rdata[k], 32'hDEADBEEF);
    @(negedge clk);
    drive(k, 0, 0, 32'h0, 32'h0, 4'h0);
    if (LATS[k] >= 3) begin
      xact(k, 1, 0, 32'h30, 32'h0, 4'hF, got, lat);
      @(negedge clk);
      drive(k, 1, 0, 32'h30, 32'hCAFEF00D, 4'hF);
      seen = 0;
      for (int i = 1; i <= 7; i++) begin
        @(posedge clk); #1;
        if (rdy[k]) seen++;
        if (i == 2) begin @(negedge clk); drive(k, 0, 0, 32'h30, 32'hCAFEF00D, 4'hF); end
      end
      chk({"abort_no_ready", s}, seen, 0);
      xact(k, 0, 1, 32'h30, 32'h0, 4'h0, got, lat);
      chk({"abort_no_write", s}, got, 32'h0);
    end
    run_random(k, 40);
  endtask

  task automatic run_random(input int k, input int cnt);
    logic [31:0] a;
    int op;
    int j;
    int lat;
    bit ab;
    for (int t = 0; t < cnt; t++) begin
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2);
      ab = (LATS[k] >= 2) && ($urandom_range(0, 4) == 0);
      @(negedge clk);
      drive(k, op == 1 || op == 2, op != 1, a, $urandom, 4'($urandom_range(0, 15)));
      if (ab) begin
        j = $urandom_range(1, LATS[k] - 1);
        repeat (j) @(negedge clk);
        drive(k, 0, 0, 32'h0, 32'h0, 4'h0);
      end else begin
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
          @(posedge clk); #1;
          if (rdy[k]) lat = n;
          else begin addr[k] = $urandom; wd[k] = $urandom; be[k] = 4'($urandom); end
        end
        chk($sformatf("rand_latency[%0d]", k), lat, LATS[k]);
        @(negedge clk);
        drive(k, 0, 0, 32'h0, 32'h0, 4'h0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    int lat;
    int seen;
    rst = 1'b0;
    for (int k = 0; k < N; k++) drive(k, 0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #2;
    mon_en = 1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset_ready[%0d]", k), {31'b0, rdy[k]}, 32'd0);
      chk($sformatf("reset_rdata[%0d]", k), rdata[k], 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    fork
      run_inst(0);
      run_inst(1);
      run_inst(2);
      run_inst(3);
    join
    // reset during WAIT on the LATENCY=15 instance
    xact(3, 1, 0, 32'h40, 32'h77665544, 4'hF, got, lat);
    xact(3, 0, 1, 32'h40, 32'h0, 4'h0, got, lat);
    chk("rst_pre_rdata", got, 32'h77665544);
    @(negedge clk);
    drive(3, 1, 0, 32'h40, 32'h99999999, 4'hF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(3, 0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_rdata", rdata[3], 32'h0);
    chk("rst_mid_ready", {31'b0, rdy[3]}, 32'h0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (rdy[3]) seen++; end
    chk("rst_mid_no_ready", seen, 0);
    xact(3, 0, 1, 32'h40, 32'h0, 4'h0, got, lat);
    chk("rst_mid_no_write", got, 32'h77665544);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
